// File: rtl/fpu_core.sv
`default_nettype none
// ============================================================================
// Module   : fpu_core
// Purpose  : Multi-cycle binary32 add/multiply unit, RNE rounding, flush-to-zero.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_core #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic [INST_WIDTH-1:0] i_inst,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_CALC   = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [31:0]        r_a, r_b;
    logic               r_mul;
    logic               r_sa, r_sb;
    logic [7:0]         r_ea, r_eb;
    logic [23:0]        r_ma, r_mb;
    logic               r_special;
    logic [31:0]        r_special_val;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    // Working magnitude: value = r_sum * 2^(r_exp-127-47); bit 0 is a jam/sticky bit.
    logic [48:0]        r_sum;
    logic [31:0]        r_data;
    logic               r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_valid) w_next_state = S_UNPACK;
            S_UNPACK: w_next_state = S_CALC;
            S_CALC:   w_next_state = S_NORM;
            S_NORM:   w_next_state = S_ROUND;
            S_ROUND:  w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic w_special;
    logic [31:0] w_special_val;

    assign w_a_zero = (r_a[30:23] == 8'h00);
    assign w_b_zero = (r_b[30:23] == 8'h00);
    assign w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);

    always_comb begin
        w_special     = 1'b1;
        w_special_val = 32'd0;
        if (w_a_nan || w_b_nan) begin
            w_special_val = c_QNAN;
        end else if (!r_mul) begin
            if (w_a_inf && w_b_inf && (r_a[31] != r_b[31])) w_special_val = c_QNAN;
            else if (w_a_inf)                                w_special_val = {r_a[31], 8'hFF, 23'd0};
            else if (w_b_inf)                                w_special_val = {r_b[31], 8'hFF, 23'd0};
            else if (w_a_zero && w_b_zero)                   w_special_val = {r_a[31] & r_b[31], 31'd0};
            else                                             w_special = 1'b0;
        end else begin
            if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) w_special_val = c_QNAN;
            else if (w_a_inf || w_b_inf)  w_special_val = {r_a[31] ^ r_b[31], 8'hFF, 23'd0};
            else if (w_a_zero || w_b_zero) w_special_val = {r_a[31] ^ r_b[31], 31'd0};
            else                          w_special = 1'b0;
        end
    end

    logic              w_a_ge, w_sl;
    logic [7:0]        w_el, w_es, w_shift;
    logic [23:0]       w_ml, w_ms;
    logic [96:0]       w_align;
    logic [48:0]       w_large, w_small, w_add_sum;
    logic [47:0]       w_prod;
    logic signed [9:0] w_mul_exp;

    assign w_a_ge  = {r_ea, r_ma} >= {r_eb, r_mb};
    assign w_el    = w_a_ge ? r_ea : r_eb;
    assign w_es    = w_a_ge ? r_eb : r_ea;
    assign w_ml    = w_a_ge ? r_ma : r_mb;
    assign w_ms    = w_a_ge ? r_mb : r_ma;
    assign w_sl    = w_a_ge ? r_sa : r_sb;
    assign w_shift = w_el - w_es;
    // Bits shifted below the 49-bit window collapse into the jam bit so that
    // subtraction still borrows correctly.
    assign w_align   = {1'b0, w_ms, 72'd0} >> w_shift;
    assign w_large   = {1'b0, w_ml, 24'd0};
    assign w_small   = w_align[96:48] | {48'd0, |w_align[47:0]};
    assign w_add_sum = (r_sa ^ r_sb) ? (w_large - w_small) : (w_large + w_small);
    assign w_prod    = r_ma * r_mb;
    assign w_mul_exp = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - 10'sd127;

    logic [5:0]        w_lead, w_lshift;
    logic [48:0]       w_norm_sum;
    logic signed [9:0] w_norm_exp;

    always_comb begin
        w_lead = 6'd0;
        for (int i = 0; i < 49; i++) begin
            if (r_sum[i]) w_lead = 6'(i);
        end
        w_lshift   = 6'd47 - w_lead;
        w_norm_sum = r_sum;
        w_norm_exp = r_exp;
        if (r_sum[48]) begin
            w_norm_sum = {1'b0, r_sum[48:2], r_sum[1] | r_sum[0]};
            w_norm_exp = r_exp + 10'sd1;
        end else if (r_sum != 49'd0) begin
            w_norm_sum = r_sum << w_lshift;
            w_norm_exp = r_exp - $signed({4'd0, w_lshift});
        end
    end

    logic [23:0]       w_mant;
    logic              w_guard, w_rbit, w_sticky, w_inc;
    logic [24:0]       w_mant_rnd;
    logic [22:0]       w_frac;
    logic signed [9:0] w_rnd_exp;
    logic [31:0]       w_result;

    assign w_mant     = r_sum[47:24];
    assign w_guard    = r_sum[23];
    assign w_rbit     = r_sum[22];
    assign w_sticky   = |r_sum[21:0];
    assign w_inc      = w_guard & (w_rbit | w_sticky | w_mant[0]);
    assign w_mant_rnd = {1'b0, w_mant} + {24'd0, w_inc};
    assign w_frac     = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];
    assign w_rnd_exp  = w_mant_rnd[24] ? (r_exp + 10'sd1) : r_exp;

    always_comb begin
        w_result = {r_sign, w_rnd_exp[7:0], w_frac};
        if (r_special)                 w_result = r_special_val;
        else if (r_sum == 49'd0)       w_result = 32'd0;
        else if (w_rnd_exp >= 10'sd255) w_result = {r_sign, 8'hFF, 23'd0};
        else if (w_rnd_exp <= 10'sd0)   w_result = {r_sign, 31'd0};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_mul         <= 1'b0;
            r_sa          <= 1'b0;
            r_sb          <= 1'b0;
            r_ea          <= 8'd0;
            r_eb          <= 8'd0;
            r_ma          <= 24'd0;
            r_mb          <= 24'd0;
            r_special     <= 1'b0;
            r_special_val <= 32'd0;
            r_sign        <= 1'b0;
            r_exp         <= 10'sd0;
            r_sum         <= 49'd0;
            r_data        <= 32'd0;
            r_valid       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a   <= i_data_a;
                        r_b   <= i_data_b;
                        r_mul <= i_inst[0];
                    end
                end
                S_UNPACK: begin
                    r_sa          <= r_a[31];
                    r_sb          <= r_b[31];
                    r_ea          <= w_a_zero ? 8'd0 : r_a[30:23];
                    r_eb          <= w_b_zero ? 8'd0 : r_b[30:23];
                    r_ma          <= w_a_zero ? 24'd0 : {1'b1, r_a[22:0]};
                    r_mb          <= w_b_zero ? 24'd0 : {1'b1, r_b[22:0]};
                    r_special     <= w_special;
                    r_special_val <= w_special_val;
                end
                S_CALC: begin
                    if (r_mul) begin
                        r_sign <= r_sa ^ r_sb;
                        r_exp  <= w_mul_exp;
                        r_sum  <= {w_prod, 1'b0};
                    end else begin
                        r_sign <= w_sl;
                        r_exp  <= $signed({2'b00, w_el});
                        r_sum  <= w_add_sum;
                    end
                end
                S_NORM: begin
                    r_sum <= w_norm_sum;
                    r_exp <= w_norm_exp;
                end
                S_ROUND: begin
                    r_data  <= w_result;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fpu_core.sv
`default_nettype none
// tb_fpu_core: directed and randomized checks of fpu_core against a
// double-precision reference model rounded to binary32.
module tb_fpu_core;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] data_a = 32'd0;
    logic [31:0] data_b = 32'd0;
    logic [0:0]  inst   = 1'b0;
    logic        valid  = 1'b0;
    logic [31:0] o_data;
    logic        o_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_core #(.DATA_WIDTH(32), .INST_WIDTH(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data_a(data_a),
        .i_data_b(data_b),
        .i_inst  (inst),
        .i_valid (valid),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

    // binary32 -> double, with exponent-0 inputs read as signed zero
    function automatic real f2d(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00)      d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) d = (f[22:0] != 23'd0) ? 64'h7FF8_0000_0000_0000 : {f[31], 11'h7FF, 52'd0};
        else                        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // exact double -> binary32 with round-to-nearest-even and flush-to-zero
    function automatic logic [31:0] d2f(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] k;
        logic        up;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF) return (d[51:0] != 52'd0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'd0};
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        m  = {1'b1, d[51:0]};
        up = (m[28:0] > 29'h1000_0000) || ((m[28:0] == 29'h1000_0000) && m[29]);
        k  = {1'b0, m[52:29]} + {24'd0, up};
        e  = int'(d[62:52]) - 1023 + 127;
        if (k[24]) begin
            e = e + 1;
            k = k >> 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], e[7:0], k[22:0]};
    endfunction

    function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic m);
        return d2f(m ? (f2d(a) * f2d(b)) : (f2d(a) + f2d(b)));
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m, input bit imm,
                          output logic [31:0] res, output int lat, output bit got);
        if (!imm) @(negedge clk);
        data_a = a;
        data_b = b;
        inst   = m;
        valid  = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        got   = 1'b0;
        lat   = 0;
        res   = 32'd0;
        for (int k = 0; k < 16 && !got; k++) begin
            if (o_valid) begin
                got = 1'b1;
                res = o_data;
            end else begin
                lat++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++;
        if (o_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", o_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_directed();
        logic [31:0] va [17] = '{32'h3F800000, 32'h3FC00000, 32'h7F000000, 32'h3F800000, 32'h3F800001,
                                 32'h3F800000, 32'h7F800000, 32'h00000000, 32'h80000000, 32'h7F800000,
                                 32'h7F800001, 32'hFF800000, 32'h7F800000, 32'h00800000, 32'h00000001,
                                 32'h80400000, 32'h3F800000};
        logic [31:0] vb [17] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h33800000, 32'h33800000,
                                 32'hBF800000, 32'hFF800000, 32'hC0000000, 32'h80000000, 32'h00000000,
                                 32'h3F800000, 32'h3F800000, 32'hC0000000, 32'h00800000, 32'h3F800000,
                                 32'h3F800000, 32'h3F800000};
        logic        vm [17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ve [17] = '{32'h40400000, 32'h40400000, 32'h7F800000, 32'h3F800000, 32'h3F800002,
                                 32'h00000000, 32'h7FC00000, 32'h80000000, 32'h80000000, 32'h7FC00000,
                                 32'h7FC00000, 32'hFF800000, 32'hFF800000, 32'h00000000, 32'h3F800000,
                                 32'h80000000, 32'h40000000};
        logic [31:0] res;
        int          lat;
        bit          got;
        for (int t = 0; t < 17; t++) begin
            run_op(va[t], vb[t], vm[t], 1'b0, res, lat, got);
            checks++;
            if (!got || res !== ve[t]) begin
                failures++;
                $display("FAIL directed[%0d] %h op%0d %h: got %h (valid=%0d) expected %h", t, va[t], vm[t], vb[t], res, got, ve[t]);
            end
            checks++;
            if (lat != 4) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected 4", t, lat); end
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin failures++; $display("FAIL directed_pulse[%0d]: o_valid got %b expected 0", t, o_valid); end
            checks++;
            if (o_data !== ve[t]) begin failures++; $display("FAIL directed_hold[%0d]: got %h expected %h", t, o_data, ve[t]); end
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] sp [6] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC12345, 32'h00400000};
        logic [31:0] a, b, expv, res;
        logic        m;
        int          ea, eb, lat;
        bit          got;
        for (int t = 0; t < n; t++) begin
            m  = 1'($urandom_range(0, 1));
            ea = int'($urandom_range(1, 254));
            if (m) eb = int'($urandom_range(1, 254));
            else   eb = ea + int'($urandom_range(0, 40)) - 20;
            if (eb < 1)   eb = 1;
            if (eb > 254) eb = 254;
            a = {1'($urandom), 8'(ea), 23'($urandom)};
            b = {1'($urandom), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 7) == 0) a = sp[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) b = sp[$urandom_range(0, 5)];
            expv = ref_model(a, b, m);
            run_op(a, b, m, 1'b0, res, lat, got);
            checks++;
            if (!got || res !== expv) begin
                failures++;
                $display("FAIL random[%0d] %h op%0d %h: got %h (valid=%0d) expected %h", t, a, m, b, res, got, expv);
            end
            checks++;
            if (lat != 4) begin failures++; $display("FAIL random_latency[%0d]: got %0d expected 4", t, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        bit          got;
        run_op(32'h3FC00000, 32'h40000000, 1'b1, 1'b0, res, lat, got);
        checks++;
        if (!got || res !== 32'h40400000) begin failures++; $display("FAIL b2b_first: got %h expected 40400000", res); end
        run_op(32'h40400000, 32'h3F800000, 1'b0, 1'b1, res, lat, got);
        checks++;
        if (!got || res !== 32'h40800000) begin failures++; $display("FAIL b2b_second: got %h expected 40800000", res); end
        checks++;
        if (lat != 4) begin failures++; $display("FAIL b2b_second_latency: got %0d expected 4", lat); end
        run_op(32'h40800000, 32'hC0000000, 1'b1, 1'b1, res, lat, got);
        checks++;
        if (!got || res !== 32'hC1000000) begin failures++; $display("FAIL b2b_third: got %h expected c1000000", res); end
    endtask

    task automatic test_busy_drop();
        logic [31:0] first, res;
        int          pulses, lat;
        bit          got;
        @(negedge clk);
        data_a = 32'h3F800000; data_b = 32'h40000000; inst = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        data_a = 32'h40000000; data_b = 32'h40000000; inst = 1'b1; valid = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        pulses = 0;
        first  = 32'd0;
        for (int k = 0; k < 14; k++) begin
            if (o_valid) begin
                pulses++;
                if (pulses == 1) first = o_data;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
        checks++;
        if (first !== 32'h40400000) begin failures++; $display("FAIL busy_data: got %h expected 40400000", first); end

        data_a = 32'h3F800000; data_b = 32'h40000000; inst = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        got   = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (o_valid) got = 1'b1;
            else         @(negedge clk);
        end
        checks++;
        if (!got || o_data !== 32'h40400000) begin failures++; $display("FAIL busy_reissue_setup: got %h expected 40400000", o_data); end
        run_op(32'h40000000, 32'h40000000, 1'b1, 1'b1, res, lat, got);
        checks++;
        if (!got || res !== 32'h40800000) begin failures++; $display("FAIL busy_reissue: got %h expected 40800000", res); end
        checks++;
        if (lat != 4) begin failures++; $display("FAIL busy_reissue_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        int          pulses, lat;
        bit          got;
        @(negedge clk);
        data_a = 32'h3F800000; data_b = 32'h40000000; inst = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_data !== 32'd0) begin failures++; $display("FAIL midreset_data: got %h expected 00000000", o_data); end
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b expected 0", o_valid); end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL midreset_pulses: got %0d expected 0", pulses); end
        run_op(32'h40000000, 32'h40000000, 1'b1, 1'b0, res, lat, got);
        checks++;
        if (!got || res !== 32'h40800000) begin failures++; $display("FAIL midreset_next: got %h expected 40800000", res); end
        checks++;
        if (lat != 4) begin failures++; $display("FAIL midreset_next_latency: got %0d expected 4", lat); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_drop();
        test_random(80);
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
